// File: rtl/msk_ark_pipe.sv
// Masked AddRoundKey stage: share-wise XOR of state and round-key sharings
// into a 2-entry skid buffer that tags each word with its AES column index.

module msk_xor_gadget #(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 32
) (
  input  logic [count*d-1:0] a,
  input  logic [count*d-1:0] b,
  output logic [count*d-1:0] y
);

  // Each output share sees only the same-index shares of a and b.
  for (genvar gi = 0; gi < count; gi++) begin : g_bit
    for (genvar gj = 0; gj < d; gj++) begin : g_share
      assign y[gi*d+gj] = a[gi*d+gj] ^ b[gi*d+gj];
    end
  end

endmodule

module msk_ark_pipe #(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [count*d-1:0]   in_state,
  input  logic [count*d-1:0]   in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [count*d-1:0]   out_sh,
  output logic [1:0]           out_col,
  output logic                 out_last
);

  localparam int unsigned W = count * d;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [W-1:0] head_sh_q, head_sh_d;
  logic [1:0]   head_col_q, head_col_d;
  logic         head_last_q, head_last_d;
  logic [W-1:0] tail_sh_q, tail_sh_d;
  logic [1:0]   tail_col_q, tail_col_d;
  logic         tail_last_q, tail_last_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic [W-1:0] new_sh;
  logic         new_last;
  logic         acc;
  logic         dlv;

  msk_xor_gadget #(
    .d     (d),
    .count (count)
  ) u_xor (
    .a (in_state),
    .b (in_key),
    .y (new_sh)
  );

  // Occupancy FSM and entry moves; flush wins over any accept or deliver.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    head_sh_d   = head_sh_q;
    head_col_d  = head_col_q;
    head_last_d = head_last_q;
    tail_sh_d   = tail_sh_q;
    tail_col_d  = tail_col_q;
    tail_last_d = tail_last_q;
    acc         = in_valid & in_ready_q;
    dlv         = out_valid_q & out_ready;
    new_last    = (col_q == 2'd3);

    if (flush) begin
      state_d     = S_EMPTY;
      col_d       = 2'd0;
      head_sh_d   = '0;
      head_col_d  = 2'd0;
      head_last_d = 1'b0;
      tail_sh_d   = '0;
      tail_col_d  = 2'd0;
      tail_last_d = 1'b0;
    end else begin
      if (acc) begin
        col_d = col_q + 2'd1;
      end
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            head_sh_d   = new_sh;
            head_col_d  = col_q;
            head_last_d = new_last;
            state_d     = S_ONE;
          end
        end
        S_ONE: begin
          if (acc && dlv) begin
            head_sh_d   = new_sh;
            head_col_d  = col_q;
            head_last_d = new_last;
          end else if (acc) begin
            tail_sh_d   = new_sh;
            tail_col_d  = col_q;
            tail_last_d = new_last;
            state_d     = S_FULL;
          end else if (dlv) begin
            head_sh_d   = '0;
            head_col_d  = 2'd0;
            head_last_d = 1'b0;
            state_d     = S_EMPTY;
          end
        end
        S_FULL: begin
          if (dlv) begin
            head_sh_d   = tail_sh_q;
            head_col_d  = tail_col_q;
            head_last_d = tail_last_q;
            tail_sh_d   = '0;
            tail_col_d  = 2'd0;
            tail_last_d = 1'b0;
            state_d     = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      col_q       <= 2'd0;
      head_sh_q   <= '0;
      head_col_q  <= 2'd0;
      head_last_q <= 1'b0;
      tail_sh_q   <= '0;
      tail_col_q  <= 2'd0;
      tail_last_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      head_sh_q   <= head_sh_d;
      head_col_q  <= head_col_d;
      head_last_q <= head_last_d;
      tail_sh_q   <= tail_sh_d;
      tail_col_q  <= tail_col_d;
      tail_last_q <= tail_last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sh    = head_sh_q;
  assign out_col   = head_col_q;
  assign out_last  = head_last_q;

endmodule

// File: tb/tb_msk_ark_pipe.sv
// Bench for msk_ark_pipe: directed table and corner sequences on a d=2 instance,
// randomized traffic against a queue model on a d=3 instance.

module tb_msk_ark_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // d=2 instance
  logic        flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic        in_ready2, out_valid2, out_last2;
  logic [63:0] in_state2 = '0, in_key2 = '0, out_sh2;
  logic [1:0]  out_col2;

  // d=3 instance
  logic        flush3 = 1'b0, in_valid3 = 1'b0, out_ready3 = 1'b0;
  logic        in_ready3, out_valid3, out_last3;
  logic [95:0] in_state3 = '0, in_key3 = '0, out_sh3;
  logic [1:0]  out_col3;

  msk_ark_pipe #(.d(2), .count(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_state(in_state2), .in_key(in_key2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sh(out_sh2), .out_col(out_col2), .out_last(out_last2)
  );

  msk_ark_pipe #(.d(3), .count(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_state(in_state3), .in_key(in_key3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sh(out_sh3), .out_col(out_col3), .out_last(out_last3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_sh(input logic [2:0][31:0] sh, input int dd);
    logic [127:0] r = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < dd; j++)
        r[i*dd+j] = sh[j][i];
    return r;
  endfunction

  function automatic logic [31:0] get_share(input logic [127:0] v, input int dd, input int j);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[i*dd+j];
    return r;
  endfunction

  function automatic logic [31:0] unmask(input logic [127:0] v, input int dd);
    logic [31:0] r = '0;
    for (int j = 0; j < dd; j++) r = r ^ get_share(v, dd, j);
    return r;
  endfunction

  task automatic put2(input logic [2:0][31:0] s, input logic [2:0][31:0] k);
    in_state2 = 64'(pack_sh(s, 2));
    in_key2   = 64'(pack_sh(k, 2));
  endtask

  task automatic head2(input string nm, input logic [2:0][31:0] s, input logic [2:0][31:0] k,
                       input logic [1:0] col);
    chk({nm, "_valid"}, 128'(out_valid2), 128'(1'b1));
    chk({nm, "_sh0"}, 128'(get_share(128'(out_sh2), 2, 0)), 128'(s[0] ^ k[0]));
    chk({nm, "_sh1"}, 128'(get_share(128'(out_sh2), 2, 1)), 128'(s[1] ^ k[1]));
    chk({nm, "_col"}, 128'(out_col2), 128'(col));
    chk({nm, "_last"}, 128'(out_last2), 128'(col == 2'd3));
  endtask

  typedef struct {
    logic [31:0] s0, s1, k0, k1, plain;
    logic [1:0]  col;
  } vec_t;

  typedef struct {
    logic [127:0] sh;
    logic [31:0]  plain;
    logic [1:0]   col;
  } word_t;

  vec_t  tbl[5];
  word_t q[$];

  initial begin
    logic [2:0][31:0] sa, ka, sb, kb, sc, kc, st, ky, ex;
    logic [31:0]      plain;
    logic [1:0]       mcol;
    bit               m_acc, m_dlv;
    int               sz;

    tbl[0] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFF0000, 32'h00FF00FF, 32'h55AAAA55, 2'd0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 2'd1};
    tbl[2] = '{32'h12345678, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 2'd2};
    tbl[3] = '{32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 2'd3};
    tbl[4] = '{32'h0000FFFF, 32'h0F0F0000, 32'h00000000, 32'hF0F00000, 32'hFFFFFFFF, 2'd0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid2), 128'(0));
    chk("rst_in_ready", 128'(in_ready2), 128'(0));
    chk("rst_out_sh", 128'(out_sh2), 128'(0));
    chk("rst_out_col", 128'(out_col2), 128'(0));
    chk("rst_out_last", 128'(out_last2), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 128'(in_ready2), 128'(1));

    // Back-to-back table vectors, out_ready high: one word per cycle
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st = '0; ky = '0;
      st[0] = tbl[i].s0; st[1] = tbl[i].s1; ky[0] = tbl[i].k0; ky[1] = tbl[i].k1;
      put2(st, ky);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_plain", i), 128'(unmask(128'(out_sh2), 2)), 128'(tbl[i].plain));
      chk($sformatf("tbl%0d_ready", i), 128'(in_ready2), 128'(1));
      head2($sformatf("tbl%0d", i), st, ky, tbl[i].col);
    end
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("tbl_drain_valid", 128'(out_valid2), 128'(0));
    chk("tbl_drain_sh", 128'(out_sh2), 128'(0));

    // Backpressure: two accepted, third held until first delivered
    sa = '0; ka = '0; sb = '0; kb = '0; sc = '0; kc = '0;
    for (int j = 0; j < 2; j++) begin
      sa[j] = $urandom; ka[j] = $urandom; sb[j] = $urandom;
      kb[j] = $urandom; sc[j] = $urandom; kc[j] = $urandom;
    end
    out_ready2 = 1'b0; in_valid2 = 1'b1; put2(sa, ka);
    @(posedge clk); #1;
    head2("bp_a1", sa, ka, 2'd1);
    chk("bp_ready1", 128'(in_ready2), 128'(1));
    put2(sb, kb);
    @(posedge clk); #1;
    chk("bp_ready2", 128'(in_ready2), 128'(0));
    head2("bp_a2", sa, ka, 2'd1);
    put2(sc, kc);
    @(posedge clk); #1;
    chk("bp_ready3", 128'(in_ready2), 128'(0));
    head2("bp_a3", sa, ka, 2'd1);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    head2("bp_b", sb, kb, 2'd2);
    chk("bp_ready4", 128'(in_ready2), 128'(1));
    @(posedge clk); #1;
    head2("bp_c", sc, kc, 2'd3);
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty", 128'(out_valid2), 128'(0));

    // Flush at occupancy 2, counter 2
    out_ready2 = 1'b0; in_valid2 = 1'b1; put2(sa, kb);
    @(posedge clk); #1;
    put2(sb, ka);
    @(posedge clk); #1;
    chk("fl_full", 128'(in_ready2), 128'(0));
    flush2 = 1'b1; out_ready2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0;
    chk("fl_valid", 128'(out_valid2), 128'(0));
    chk("fl_ready", 128'(in_ready2), 128'(1));
    chk("fl_sh", 128'(out_sh2), 128'(0));
    put2(sc, ka);
    @(posedge clk); #1;
    head2("fl_next", sc, ka, 2'd0);
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("fl_drain", 128'(out_valid2), 128'(0));

    // Asynchronous reset mid-cycle with one word buffered
    out_ready2 = 1'b0; in_valid2 = 1'b1; put2(sb, kc);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    head2("ar_pre", sb, kc, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid2), 128'(0));
    chk("ar_sh", 128'(out_sh2), 128'(0));
    chk("ar_ready", 128'(in_ready2), 128'(0));
    chk("ar_col", 128'(out_col2), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_post_ready", 128'(in_ready2), 128'(1));
    chk("ar_post_valid", 128'(out_valid2), 128'(0));

    // Random d=3 traffic against a queue model
    mcol = 2'd0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      st = '0; ky = '0; ex = '0; plain = '0;
      for (int j = 0; j < 3; j++) begin
        st[j] = $urandom; ky[j] = $urandom; ex[j] = st[j] ^ ky[j];
        plain = plain ^ st[j] ^ ky[j];
      end
      in_state3  = 96'(pack_sh(st, 3));
      in_key3    = 96'(pack_sh(ky, 3));
      in_valid3  = ($urandom_range(0, 3) != 0);
      out_ready3 = ($urandom_range(0, 2) != 0);
      flush3     = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      sz = q.size();
      chk("rnd_in_ready", 128'(in_ready3), 128'(sz < 2));
      chk("rnd_out_valid", 128'(out_valid3), 128'(sz > 0));
      if (sz > 0) begin
        chk("rnd_sh", 128'(out_sh3), q[0].sh);
        chk("rnd_plain", 128'(unmask(128'(out_sh3), 3)), 128'(q[0].plain));
        chk("rnd_col", 128'(out_col3), 128'(q[0].col));
        chk("rnd_last", 128'(out_last3), 128'(q[0].col == 2'd3));
      end else begin
        chk("rnd_sh_zero", 128'(out_sh3), 128'(0));
      end
      if (flush3) begin
        q.delete();
        mcol = 2'd0;
      end else begin
        m_acc = in_valid3 && (sz < 2);
        m_dlv = out_ready3 && (sz > 0);
        if (m_dlv) void'(q.pop_front());
        if (m_acc) begin
          q.push_back('{pack_sh(ex, 3), plain, mcol});
          mcol = mcol + 2'd1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
